xbus_slave_mem: RTL

- Byte-addressed memory slave on the XBUS, downstream of the arbiter.
- Watches the address phase qualified by sig_start and claims transfers that fall in its address window.
- Serves the data phase with a programmable number of wait states per beat, and flags out-of-window bursts and burst-length mismatches on sig_error.
- Forms the memory endpoint that the bench's masters target.

---
 rtl/xbus_slave_pkg.sv | 17 +
 rtl/xbus_slave_ram.sv | 31 +++
 rtl/xbus_slave_mem.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/xbus_slave_pkg.sv
// Shared types and helpers for the XBUS memory slave.
package xbus_slave_pkg;

    localparam int unsigned MAX_BEATS = 8;

    typedef enum logic [1:0] {
        StIdle,
        StData,
        StErr
    } state_e;

    // Burst length encoding: 00=1, 01=2, 10=4, 11=8 beats.
    function automatic logic [3:0] size_to_len(input logic [1:0] size);
        return 4'd1 << size;
    endfunction

endpackage

// File: rtl/xbus_slave_ram.sv
// Single-port byte RAM: synchronous clear on reset, registered read, write enable.
module xbus_slave_ram #(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [7:0]    wdata,
    output logic [7:0]    rdata
);

    logic [7:0] mem [DEPTH];

    // Storage and read register; reset has priority so no write lands on a reset edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= 8'h00;
            end
            rdata <= 8'h00;
        end else begin
            if (we) begin
                mem[addr] <= wdata;
            end
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/xbus_slave_mem.sv
// XBUS memory slave: address decode, burst FSM, wait-state and beat counters.
module xbus_slave_mem
    import xbus_slave_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 16,
    parameter int unsigned BASE_ADDR   = 16'h0100,
    parameter int unsigned MEM_DEPTH   = 256,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic                  sig_clock,
    input  logic                  sig_reset,
    input  logic                  sig_start,
    input  logic [ADDR_WIDTH-1:0] sig_addr,
    input  logic [1:0]            sig_size,
    input  logic                  sig_read,
    input  logic                  sig_write,
    input  logic                  sig_bip,
    input  logic [7:0]            sig_data_in,
    output logic [7:0]            sig_data_out,
    output logic                  sig_data_oe,
    output logic                  sig_wait,
    output logic                  sig_error
);

    localparam int unsigned OW = $clog2(MEM_DEPTH);

    state_e          state_q, state_d;
    logic [OW-1:0]   offset_q, offset_d;
    logic [3:0]      len_q, len_d;
    logic [2:0]      beat_q, beat_d;
    logic [2:0]      wait_q, wait_d;
    logic            rd_q, rd_d;

    logic [ADDR_WIDTH-1:0] diff;
    logic [3:0]            req_len;
    logic                  in_win, fits, dir_ok;
    logic                  active, beat_done, last_beat, bip_bad;
    logic [OW-1:0]         cur_addr, ram_addr;
    logic                  ram_we;
    logic [7:0]            ram_rdata;

    // Address decode for the start cycle; a wrapped difference lands outside the window.
    always_comb begin
        diff    = sig_addr - ADDR_WIDTH'(BASE_ADDR);
        req_len = size_to_len(sig_size);
        in_win  = (sig_addr >= ADDR_WIDTH'(BASE_ADDR)) && (32'(diff) < MEM_DEPTH);
        fits    = (32'(diff) + 32'(req_len)) <= MEM_DEPTH;
        dir_ok  = sig_read ^ sig_write;
    end

    // Beat status derived from the counters.
    always_comb begin
        active    = (state_q != StIdle);
        beat_done = active && (wait_q == 3'(WAIT_CYCLES));
        last_beat = ({1'b0, beat_q} == (len_q - 4'd1));
        bip_bad   = (sig_bip != !last_beat);
        cur_addr  = offset_q + OW'(beat_q);
    end

    // Next-state logic for the FSM and counters.
    always_comb begin
        state_d  = state_q;
        offset_d = offset_q;
        len_d    = len_q;
        beat_d   = beat_q;
        wait_d   = wait_q;
        rd_d     = rd_q;
        unique case (state_q)
            StIdle: begin
                if (sig_start && dir_ok && in_win) begin
                    state_d  = fits ? StData : StErr;
                    offset_d = diff[OW-1:0];
                    len_d    = req_len;
                    beat_d   = 3'd0;
                    wait_d   = 3'd0;
                    rd_d     = sig_read;
                end
            end
            StData, StErr: begin
                if (beat_done) begin
                    wait_d = 3'd0;
                    if (last_beat) begin
                        state_d = StIdle;
                    end else begin
                        beat_d = beat_q + 3'd1;
                    end
                end else begin
                    wait_d = wait_q + 3'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and counter registers.
    always_ff @(posedge sig_clock) begin
        if (sig_reset) begin
            state_q  <= StIdle;
            offset_q <= '0;
            len_q    <= 4'd0;
            beat_q   <= 3'd0;
            wait_q   <= 3'd0;
            rd_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            offset_q <= offset_d;
            len_q    <= len_d;
            beat_q   <= beat_d;
            wait_q   <= wait_d;
            rd_q     <= rd_d;
        end
    end

    // RAM port: prefetch the next beat so read data is valid from each beat's first cycle.
    always_comb begin
        ram_we = (state_q == StData) && !rd_q && beat_done;
        if (state_q == StIdle) begin
            ram_addr = diff[OW-1:0];
        end else if (beat_done && rd_q) begin
            ram_addr = cur_addr + OW'(1);
        end else begin
            ram_addr = cur_addr;
        end
    end

    xbus_slave_ram #(
        .DEPTH (MEM_DEPTH)
    ) u_ram (
        .clk   (sig_clock),
        .rst   (sig_reset),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (sig_data_in),
        .rdata (ram_rdata)
    );

    // Bus outputs; errored reads drive zero data.
    always_comb begin
        sig_wait     = active && !beat_done;
        sig_error    = beat_done && ((state_q == StErr) || bip_bad);
        sig_data_oe  = active && rd_q;
        sig_data_out = ((state_q == StData) && rd_q) ? ram_rdata : 8'h00;
    end

endmodule
